imm_ext: RTL and testbench
==========================

Name: imm_ext

Overview:
- Registered immediate extender for the MIPS datapath, placed in the decode stage between instruction field extraction and the ALU operand / branch-target mux.
- Takes a 16-bit immediate and a 2-bit extend opcode, and produces a 32-bit extended value one clock later.
- Carries a valid flag and honours a pipeline stall.

Parameters:
- IMM_W, 16, immediate input width.
- DATA_W, 32, output width; must satisfy DATA_W >= 2*IMM_W.
- BR_SHIFT, 2, left-shift amount applied in branch-offset mode.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous reset, active-low.
- imm  input  IMM_W  raw immediate field.
- eop  input  2  extend opcode.
- in_valid  input  1  imm/eop are meaningful this cycle.
- stall  input  1  hold all output registers.
- ext  output  DATA_W  registered extended result.
- out_valid  output  1  ext carries a freshly computed result.

Behaviour:
- Reset:
  - rst_n low asynchronously forces ext = 0 and out_valid = 0.
  - Release is synchronous to the next clk edge.
- Combinational function f(imm, eop):
  - eop=0: zero-extend, {DATA_W-IMM_W zeros, imm}.
  - eop=1: sign-extend, imm[IMM_W-1] replicated into the upper bits.
  - eop=2: load-upper, {imm, IMM_W zeros} (upper bits above 2*IMM_W zero if DATA_W > 32).
  - eop=3: branch offset, sign-extend(imm) << BR_SHIFT; bits shifted out of the top are discarded; the low BR_SHIFT bits are 0.
- Each rising clk edge with rst_n high:
  - stall=1: ext and out_valid hold their values; stall takes priority over in_valid.
  - stall=0, in_valid=1: ext <= f(imm, eop), out_valid <= 1.
  - stall=0, in_valid=0: out_valid <= 0; ext holds its last value and does not clear.
- Latency is exactly 1 cycle from in_valid sampled to out_valid/ext visible. Throughput is one result per cycle with no bubbles.
- No internal state other than the output registers. The function is pure, so back-to-back mode changes are independent.
- Reset asserted mid-stall clears the outputs immediately; stall is irrelevant while rst_n is low.
- X on eop while in_valid=0 must not propagate to ext.

Optional Feature:
- IMM_EXT_STATUS_EN defined: two extra registered outputs, updated under the same enable as ext and cleared to 0 on reset.
  - ext_zero (1 bit): f(...) == 0.
  - ext_neg (1 bit): f(...)[DATA_W-1].
- Not defined: these ports do not exist; all other behaviour is identical.

Test Plan:
- Reset: drive rst_n=0 mid-cycle with ext previously 0x1234 -> ext=0x00000000 and out_valid=0 without waiting for a clock edge.
- Zero/sign-extend:
  - imm=0xFFFD, eop=0, in_valid=1 -> next cycle ext=0x0000FFFD, out_valid=1.
  - same imm, eop=1 -> ext=0xFFFFFFFD.
- Load-upper / branch:
  - imm=0xFFFD (-3), eop=3 -> ext=0xFFFFFFF4.
  - imm=0x1234, eop=2 -> ext=0x12340000.
  - imm=0x7FFF, eop=3 -> ext=0x0001FFFC.
- Stall: load 0x0000ABCD, then assert stall with imm=0x0001, eop=0, in_valid=1 for 3 cycles -> ext stays 0x0000ABCD and out_valid stays 1; release -> ext=0x00000001.
- Valid drop: in_valid=0 after a result 0x12340000 -> next cycle out_valid=0 and ext still 0x12340000.
- Back-to-back: eop cycling 0,1,2,3 with imm=0x8000 every cycle -> ext sequence 0x00008000, 0xFFFF8000, 0x80000000, 0xFFFE0000 on consecutive cycles. With IMM_EXT_STATUS_EN, ext_neg sequence is 0,1,1,1.

Source files
------------

// File: rtl/imm_ext.sv
// -----------------------------------------------------------------------------
// imm_ext -- registered immediate extender for the MIPS decode stage
//
// Purpose:
//   Turns a raw IMM_W-bit instruction immediate into a DATA_W-bit operand one
//   clock after it is presented. It sits between instruction field extraction
//   and the ALU operand / branch-target mux. The only state is the output
//   register set.
//
// Extend opcodes (eop):
//   2'd0  zero-extend      {0..0, imm}
//   2'd1  sign-extend      {imm[MSB]..imm[MSB], imm}
//   2'd2  load-upper       {0.., imm, IMM_W zeros}
//   2'd3  branch offset    sign-extend(imm) << BR_SHIFT, top bits discarded
//
// Ports:
//   clk        in   1       rising-edge clock
//   rst_n      in   1       asynchronous active-low reset (sync release)
//   imm        in   IMM_W   raw immediate field
//   eop        in   2       extend opcode
//   in_valid   in   1       imm/eop are meaningful this cycle
//   stall      in   1       hold every output register
//   ext        out  DATA_W  registered extended result
//   out_valid  out  1       ext carries a freshly computed result
//   ext_zero   out  1       (IMM_EXT_STATUS_EN only) registered f == 0
//   ext_neg    out  1       (IMM_EXT_STATUS_EN only) registered f[DATA_W-1]
//
// Configuration macro:
//   IMM_EXT_STATUS_EN  adds the ext_zero / ext_neg status outputs. When it is
//                      undefined those ports do not exist and everything else
//                      is unchanged.
//
// Handshake:
//   A result is accepted on a rising edge when in_valid=1 and stall=0; it is
//   visible on ext with out_valid=1 exactly one cycle later. stall=1 freezes
//   every output register and wins over in_valid. With stall=0 and
//   in_valid=0, out_valid drops to 0 and ext keeps its last value, so a
//   consumer must qualify ext with out_valid.
// -----------------------------------------------------------------------------
module imm_ext #(
    parameter int IMM_W    = 16,
    parameter int DATA_W   = 32,
    parameter int BR_SHIFT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [IMM_W-1:0]  imm,
    input  logic [1:0]        eop,
    input  logic              in_valid,
    input  logic              stall,
    output logic [DATA_W-1:0] ext,
`ifdef IMM_EXT_STATUS_EN
    output logic              ext_zero,
    output logic              ext_neg,
`endif
    output logic              out_valid
);

    // Elaboration-time guard: load-upper needs room for imm plus IMM_W zeros.
    generate
        if (DATA_W < 2 * IMM_W) begin : g_bad_width
            $error("imm_ext: DATA_W must be at least 2*IMM_W");
        end
    endgenerate

    localparam logic [1:0] EOP_ZERO   = 2'd0;
    localparam logic [1:0] EOP_SIGN   = 2'd1;
    localparam logic [1:0] EOP_UPPER  = 2'd2;
    localparam logic [1:0] EOP_BRANCH = 2'd3;

    // -------------------------------------------------------------------------
    // Combinational extend function f(imm, eop)
    // -------------------------------------------------------------------------
    logic [DATA_W-1:0] w_zext;
    logic [DATA_W-1:0] w_sext;
    logic [DATA_W-1:0] w_upper;
    logic [DATA_W-1:0] w_branch;
    logic [DATA_W-1:0] w_f;

    assign w_zext   = {{(DATA_W-IMM_W){1'b0}}, imm};
    assign w_sext   = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
    // Any bits above 2*IMM_W are zero when DATA_W is wider than 2*IMM_W.
    assign w_upper  = DATA_W'({imm, {IMM_W{1'b0}}});
    // Shifting the already sign-extended value drops the top BR_SHIFT bits
    // and fills the low BR_SHIFT bits with zero.
    assign w_branch = w_sext << BR_SHIFT;

    always_comb begin
        w_f = w_zext;
        case (eop)
            EOP_ZERO:   w_f = w_zext;
            EOP_SIGN:   w_f = w_sext;
            EOP_UPPER:  w_f = w_upper;
            EOP_BRANCH: w_f = w_branch;
            default:    w_f = w_zext;
        endcase
    end

    // -------------------------------------------------------------------------
    // Register enables
    // -------------------------------------------------------------------------
    // w_adv: the pipeline advances this cycle (not stalled).
    // w_load: a new result is captured. ext only changes on w_load, so an
    // unknown eop while in_valid=0 can never reach the register.
    logic w_adv;
    logic w_load;

    assign w_adv  = ~stall;
    assign w_load = w_adv & in_valid;

    // -------------------------------------------------------------------------
    // Output registers
    // -------------------------------------------------------------------------
    logic [DATA_W-1:0] r_ext;
    logic              r_out_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ext <= '0;
        end else if (w_load) begin
            r_ext <= w_f;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
        end else if (w_adv) begin
            r_out_valid <= in_valid;
        end
    end

    assign ext       = r_ext;
    assign out_valid = r_out_valid;

`ifdef IMM_EXT_STATUS_EN
    // Status flags follow the same enable as ext. They are computed from f
    // rather than from r_ext so they line up with ext in the same cycle; note
    // that after reset ext=0 yet ext_zero=0, because nothing was computed.
    logic w_f_zero;
    logic w_f_neg;
    logic r_ext_zero;
    logic r_ext_neg;

    assign w_f_zero = (w_f == '0);
    assign w_f_neg  = w_f[DATA_W-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ext_zero <= 1'b0;
            r_ext_neg  <= 1'b0;
        end else if (w_load) begin
            r_ext_zero <= w_f_zero;
            r_ext_neg  <= w_f_neg;
        end
    end

    assign ext_zero = r_ext_zero;
    assign ext_neg  = r_ext_neg;
`endif

endmodule

// File: tb/tb_imm_ext.sv
module tb_imm_ext;

  localparam int IMM_W    = 16;
  localparam int DATA_W   = 32;
  localparam int BR_SHIFT = 2;
  // Scoreboard entry: {exp_zero, exp_neg, exp_valid, exp_ext}
  localparam int QW       = DATA_W + 3;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [IMM_W-1:0]  imm = '0;
  logic [1:0]        eop = '0;
  logic              in_valid = 1'b0;
  logic              stall = 1'b0;
  logic [DATA_W-1:0] ext;
  logic              out_valid;
`ifdef IMM_EXT_STATUS_EN
  logic              ext_zero;
  logic              ext_neg;
`endif

  always #5 clk = ~clk;

  imm_ext #(
    .IMM_W   (IMM_W),
    .DATA_W  (DATA_W),
    .BR_SHIFT(BR_SHIFT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .imm      (imm),
    .eop      (eop),
    .in_valid (in_valid),
    .stall    (stall),
    .ext      (ext),
`ifdef IMM_EXT_STATUS_EN
    .ext_zero (ext_zero),
    .ext_neg  (ext_neg),
`endif
    .out_valid(out_valid)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  logic [QW-1:0]     exp_q[$];
  int                n_tests = 0;
  int                n_fail = 0;
  logic              m_zero = 1'b0;
  logic              m_neg = 1'b0;
  logic [DATA_W-1:0] m_ext = '0;
  logic              m_vld = 1'b0;

  task automatic chk(input string nm, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic check_outputs(input string nm);
    logic [QW-1:0] e;
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: scoreboard empty, got 0x%08h expected an entry", nm, ext);
      return;
    end
    e = exp_q.pop_front();
    chk({nm, ".ext"}, ext, e[DATA_W-1:0]);
    chk({nm, ".valid"}, {31'd0, out_valid}, {31'd0, e[DATA_W]});
`ifdef IMM_EXT_STATUS_EN
    chk({nm, ".neg"}, {31'd0, ext_neg}, {31'd0, e[DATA_W+1]});
    chk({nm, ".zero"}, {31'd0, ext_zero}, {31'd0, e[DATA_W+2]});
`endif
  endtask

  // Drive one cycle of stimulus, push its expected outcome, check after the edge.
  task automatic step(input logic [IMM_W-1:0] t_imm, input logic [1:0] t_eop,
                      input logic t_vld, input logic t_stl,
                      input logic [DATA_W-1:0] t_ext, input logic t_ov, input string nm);
    @(negedge clk);
    imm      = t_imm;
    eop      = t_eop;
    in_valid = t_vld;
    stall    = t_stl;
    if (!t_stl && t_vld) begin
      m_zero = (t_ext == '0);
      m_neg  = t_ext[DATA_W-1];
    end
    m_ext = t_ext;
    m_vld = t_ov;
    exp_q.push_back({m_zero, m_neg, t_ov, t_ext});
    @(posedge clk);
    #1;
    check_outputs(nm);
  endtask

  // Reference extend function written with signed arithmetic.
  function automatic logic [DATA_W-1:0] ref_f(input logic [IMM_W-1:0] v, input logic [1:0] op);
    int s;
    s = int'($signed(v));
    case (op)
      2'd0:    ref_f = DATA_W'(v);
      2'd1:    ref_f = DATA_W'(s);
      2'd2:    ref_f = DATA_W'(v) * 32'h0001_0000;
      default: ref_f = DATA_W'(s * (1 << BR_SHIFT));
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [IMM_W-1:0]  imm;
    logic [1:0]        eop;
    logic              vld;
    logic              stl;
    logic [DATA_W-1:0] ext;
    logic              ov;
  } vec_t;

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{16'hFFFD, 2'd0, 1'b1, 1'b0, 32'h0000_FFFD, 1'b1};
    vecs[1]  = '{16'hFFFD, 2'd1, 1'b1, 1'b0, 32'hFFFF_FFFD, 1'b1};
    vecs[2]  = '{16'hFFFD, 2'd3, 1'b1, 1'b0, 32'hFFFF_FFF4, 1'b1};
    vecs[3]  = '{16'h1234, 2'd2, 1'b1, 1'b0, 32'h1234_0000, 1'b1};
    vecs[4]  = '{16'h5555, 2'd1, 1'b0, 1'b0, 32'h1234_0000, 1'b0};
    vecs[5]  = '{16'h7FFF, 2'd3, 1'b1, 1'b0, 32'h0001_FFFC, 1'b1};
    vecs[6]  = '{16'h8000, 2'd0, 1'b1, 1'b0, 32'h0000_8000, 1'b1};
    vecs[7]  = '{16'h8000, 2'd1, 1'b1, 1'b0, 32'hFFFF_8000, 1'b1};
    vecs[8]  = '{16'h8000, 2'd2, 1'b1, 1'b0, 32'h8000_0000, 1'b1};
    vecs[9]  = '{16'h8000, 2'd3, 1'b1, 1'b0, 32'hFFFE_0000, 1'b1};
    vecs[10] = '{16'h0000, 2'd1, 1'b1, 1'b0, 32'h0000_0000, 1'b1};
    vecs[11] = '{16'h0001, 2'd3, 1'b1, 1'b0, 32'h0000_0004, 1'b1};

    // Reset state before any clock edge has been released.
    #2;
    chk("reset.ext", ext, 32'h0);
    chk("reset.valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven vectors
    for (int i = 0; i < 12; i++) begin
      step(vecs[i].imm, vecs[i].eop, vecs[i].vld, vecs[i].stl, vecs[i].ext, vecs[i].ov,
           $sformatf("vec%0d", i));
    end

    // Stall: hold for three cycles with a different operand presented.
    step(16'hABCD, 2'd0, 1'b1, 1'b0, 32'h0000_ABCD, 1'b1, "stall.load");
    for (int i = 0; i < 3; i++) begin
      step(16'h0001, 2'd0, 1'b1, 1'b1, 32'h0000_ABCD, 1'b1, $sformatf("stall.hold%0d", i));
    end
    step(16'h0001, 2'd0, 1'b1, 1'b0, 32'h0000_0001, 1'b1, "stall.release");

    // Stall while out_valid is low keeps it low.
    step(16'h0002, 2'd0, 1'b0, 1'b0, 32'h0000_0001, 1'b0, "stall.idle");
    step(16'h0002, 2'd0, 1'b1, 1'b1, 32'h0000_0001, 1'b0, "stall.idle_hold");

    // Unknown eop while in_valid=0 must not disturb ext.
    step(16'hFFFF, 2'bxx, 1'b0, 1'b0, 32'h0000_0001, 1'b0, "xeop");

    // Asynchronous reset mid-cycle and mid-stall.
    step(16'h1234, 2'd0, 1'b1, 1'b0, 32'h0000_1234, 1'b1, "pre_reset");
    @(negedge clk);
    stall = 1'b1;
    in_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset.ext", ext, 32'h0);
    chk("async_reset.valid", {31'd0, out_valid}, 32'd0);
`ifdef IMM_EXT_STATUS_EN
    chk("async_reset.zero", {31'd0, ext_zero}, 32'd0);
    chk("async_reset.neg", {31'd0, ext_neg}, 32'd0);
`endif
    m_zero = 1'b0;
    m_neg  = 1'b0;
    m_ext  = '0;
    m_vld  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step(16'h0000, 2'd0, 1'b0, 1'b0, 32'h0, 1'b0, "post_reset_idle");
    step(16'hFFF0, 2'd1, 1'b1, 1'b0, 32'hFFFF_FFF0, 1'b1, "post_reset_load");

    // Randomised traffic against the reference function.
    for (int i = 0; i < 200; i++) begin
      logic [IMM_W-1:0]  r_imm;
      logic [1:0]        r_eop;
      logic              r_vld;
      logic              r_stl;
      logic [DATA_W-1:0] e_ext;
      logic              e_ov;
      r_imm = IMM_W'($urandom_range(0, 16'hFFFF));
      r_eop = 2'($urandom_range(0, 3));
      r_vld = ($urandom_range(0, 3) != 0);
      r_stl = ($urandom_range(0, 4) == 0);
      e_ext = m_ext;
      e_ov  = m_vld;
      if (!r_stl) begin
        e_ov = r_vld;
        if (r_vld) e_ext = ref_f(r_imm, r_eop);
      end
      step(r_imm, r_eop, r_vld, r_stl, e_ext, e_ov, $sformatf("rand%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
